// File: rtl/ssd1331_init_sequencer.sv
// Power-up and configuration sequencer for an SSD1331 OLED: sequences the supply
// and reset pins, then hands four command packets to a downstream SPI buffer.
module ssd1331_init_sequencer #(
   parameter int WIDTH = 8,
   parameter int N     = 8,
   parameter int T_PWR = 20000,
   parameter int T_RES = 10,
   parameter int T_VCC = 100000
) (
   input  logic               i_SCK,
   input  logic               i_RST,
   input  logic               i_EN,
   input  logic               i_MOSI_FINAL_BYTE,
   output logic [WIDTH*N-1:0] o_DATA,
   output logic [N-1:0]       o_DC,
   output logic [4:0]         o_N_transmit,
   output logic               o_START,
   output logic               o_RESn,
   output logic               o_PMODEN,
   output logic               o_VCCEN,
   output logic               o_BUSY,
   output logic               o_DONE
);

   localparam int T_MAX = (T_PWR > T_RES) ? ((T_PWR > T_VCC) ? T_PWR : T_VCC)
                                          : ((T_RES > T_VCC) ? T_RES : T_VCC);
   // The counter only ever holds T-1, so log2(T_MAX) bits are enough.
   localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(T_PWR - 1);
   localparam logic [CNT_W-1:0] RES_LOAD = CNT_W'(T_RES - 1);
   localparam logic [CNT_W-1:0] VCC_LOAD = CNT_W'(T_VCC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   typedef enum logic [2:0] {
      IDLE, PWR_WAIT, RES_LOW, RES_WAIT, SEND, WAIT_TX, VCC_WAIT, DONE
   } state_t;

   state_t               state_r, state_s;
   logic [1:0]           idx_r, idx_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic [WIDTH*N-1:0]   data_r, data_s;
   logic [4:0]           n_r, n_s;
   logic                 start_r, start_s;
   logic                 resn_r, resn_s;
   logic                 pmoden_r, pmoden_s;
   logic                 vccen_r, vccen_s;
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;

   // Command packet ROM; byte 0 lands in the least significant slot.
   function automatic logic [WIDTH*N-1:0] rom_data(input logic [1:0] idx);
      logic [7:0]         b [0:6];
      logic [WIDTH*N-1:0] d;
      for (int k = 0; k < 7; k++) b[k] = 8'h00;
      case (idx)
         2'd0: b[0] = 8'hAE;
         2'd1: begin
            b[0] = 8'hA0; b[1] = 8'h72; b[2] = 8'hA1; b[3] = 8'h00;
            b[4] = 8'hA2; b[5] = 8'h00; b[6] = 8'hA4;
         end
         2'd2: begin
            b[0] = 8'hA8; b[1] = 8'h3F; b[2] = 8'hAD;
            b[3] = 8'h8E; b[4] = 8'hB0; b[5] = 8'h0B;
         end
         default: b[0] = 8'hAF;
      endcase
      d = {(WIDTH*N){1'b0}};
      for (int k = 0; k < 7; k++) begin
         if (k < N) d[WIDTH*k +: WIDTH] = WIDTH'(b[k]);
      end
      return d;
   endfunction

   function automatic logic [4:0] rom_len(input logic [1:0] idx);
      case (idx)
         2'd0:    return 5'd1;
         2'd1:    return 5'd7;
         2'd2:    return 5'd6;
         default: return 5'd1;
      endcase
   endfunction

   // Next-state, index, delay counter and next output values.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (i_EN) begin
               state_s = PWR_WAIT;
               cnt_s   = PWR_LOAD;
               idx_s   = 2'd0;
            end else begin
               state_s = IDLE;
            end
         end
         PWR_WAIT: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = RES_LOW;
               cnt_s   = RES_LOAD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         RES_LOW: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = RES_WAIT;
               cnt_s   = RES_LOAD;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         RES_WAIT: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = SEND;
               idx_s   = 2'd0;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         SEND: state_s = WAIT_TX;
         WAIT_TX: begin
            if (i_MOSI_FINAL_BYTE) begin
               case (idx_r)
                  2'd0, 2'd1: begin
                     idx_s   = idx_r + 2'd1;
                     state_s = SEND;
                  end
                  2'd2: begin
                     idx_s   = 2'd3;
                     state_s = VCC_WAIT;
                     cnt_s   = VCC_LOAD;
                  end
                  default: state_s = DONE;
               endcase
            end else begin
               state_s = WAIT_TX;
            end
         end
         VCC_WAIT: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = SEND;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         DONE:    state_s = DONE;
         default: state_s = IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      start_s  = (state_s == SEND);
      resn_s   = (state_s != RES_LOW);
      pmoden_s = (state_s != IDLE);
      busy_s   = (state_s != IDLE) && (state_s != DONE);
      done_s   = (state_s == DONE);
      vccen_s  = (state_s == VCC_WAIT) ||
                 ((idx_s == 2'd3) && ((state_s == SEND) || (state_s == WAIT_TX) ||
                                      (state_s == DONE)));
      if ((state_s == SEND) || (state_s == WAIT_TX)) begin
         data_s = rom_data(idx_s);
         n_s    = rom_len(idx_s);
      end else begin
         data_s = {(WIDTH*N){1'b0}};
         n_s    = 5'd0;
      end
   end

   // State, counter and registered outputs.
   always_ff @(posedge i_SCK or posedge i_RST) begin
      if (i_RST) begin
         state_r  <= IDLE;
         idx_r    <= 2'd0;
         cnt_r    <= CNT_ZERO;
         data_r   <= {(WIDTH*N){1'b0}};
         n_r      <= 5'd0;
         start_r  <= 1'b0;
         resn_r   <= 1'b1;
         pmoden_r <= 1'b0;
         vccen_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_s;
         idx_r    <= idx_s;
         cnt_r    <= cnt_s;
         data_r   <= data_s;
         n_r      <= n_s;
         start_r  <= start_s;
         resn_r   <= resn_s;
         pmoden_r <= pmoden_s;
         vccen_r  <= vccen_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   assign o_DATA       = data_r;
   assign o_DC         = {N{1'b0}};
   assign o_N_transmit = n_r;
   assign o_START      = start_r;
   assign o_RESn       = resn_r;
   assign o_PMODEN     = pmoden_r;
   assign o_VCCEN      = vccen_r;
   assign o_BUSY       = busy_r;
   assign o_DONE       = done_r;

endmodule

// File: tb/tb_ssd1331_init_sequencer.sv
// Scoreboard bench for ssd1331_init_sequencer with shortened delays
// (T_PWR=4, T_RES=3, T_VCC=5); packets are popped and checked at each o_START.
module tb_ssd1331_init_sequencer;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  n;
   } pkt_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        resp_fb;
   logic        spur_fb;
   logic [63:0] data;
   logic [7:0]  dc;
   logic [4:0]  n_tx;
   logic        start, resn, pmoden, vccen, busy, done;

   int   checks;
   int   errors;
   int   start_cnt;
   int   resp_cnt;
   logic auto_resp;
   pkt_t exp_q[$];

   ssd1331_init_sequencer #(
      .WIDTH(8), .N(8), .T_PWR(4), .T_RES(3), .T_VCC(5)
   ) dut (
      .i_SCK             (clk),
      .i_RST             (rst),
      .i_EN              (en),
      .i_MOSI_FINAL_BYTE (resp_fb | spur_fb),
      .o_DATA            (data),
      .o_DC              (dc),
      .o_N_transmit      (n_tx),
      .o_START           (start),
      .o_RESn            (resn),
      .o_PMODEN          (pmoden),
      .o_VCCEN           (vccen),
      .o_BUSY            (busy),
      .o_DONE            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pkt_t mk_pkt(input int p);
      pkt_t r;
      case (p)
         0:       begin r.data = 64'h0000_0000_0000_00AE; r.n = 5'd1; end
         1:       begin r.data = 64'h00A4_00A2_00A1_72A0; r.n = 5'd7; end
         2:       begin r.data = 64'h0000_0BB0_8EAD_3FA8; r.n = 5'd6; end
         default: begin r.data = 64'h0000_0000_0000_00AF; r.n = 5'd1; end
      endcase
      return r;
   endfunction

   task automatic push_all();
      for (int p = 0; p < 4; p++) exp_q.push_back(mk_pkt(p));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_start"},  {63'd0, start},  64'd0);
      check_val({tag, "_resn"},   {63'd0, resn},   64'd1);
      check_val({tag, "_pmoden"}, {63'd0, pmoden}, 64'd0);
      check_val({tag, "_vccen"},  {63'd0, vccen},  64'd0);
      check_val({tag, "_busy"},   {63'd0, busy},   64'd0);
      check_val({tag, "_done"},   {63'd0, done},   64'd0);
      check_val({tag, "_data"},   data,            64'd0);
      check_val({tag, "_n"},      {59'd0, n_tx},   64'd0);
      check_val({tag, "_dc"},     {56'd0, dc},     64'd0);
   endtask

   task automatic pulse_en();
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask

   // Scoreboard: every strobe must match the next expected packet.
   initial begin
      pkt_t e;
      forever begin
         @(negedge clk);
         if (start === 1'b1) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
               check_val("extra_start", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check_val("pkt_data", data, e.data);
               check_val("pkt_n", {59'd0, n_tx}, {59'd0, e.n});
               check_val("pkt_dc", {56'd0, dc}, 64'd0);
            end
         end
      end
   end

   // SPI buffer model: final-byte pulse sampled 10 edges after each strobe.
   initial begin
      resp_fb  = 1'b0;
      resp_cnt = 0;
      forever begin
         @(negedge clk);
         resp_fb = 1'b0;
         if (rst) begin
            resp_cnt = 0;
         end else if (start === 1'b1 && auto_resp) begin
            resp_cnt = 9;
         end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_fb = 1'b1;
         end
      end
   end

   initial begin
      int base;
      int t;
      checks    = 0;
      errors    = 0;
      start_cnt = 0;
      auto_resp = 1'b1;
      rst       = 1'b1;
      en        = 1'b0;
      spur_fb   = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_val("idle_busy", {63'd0, busy}, 64'd0);

      // Full sequence, with a spurious final-byte pulse in PWR_WAIT.
      push_all();
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en      = 1'b0;
      spur_fb = 1'b1;
      check_val("pmoden_rise", {63'd0, pmoden}, 64'd1);
      check_val("busy_rise", {63'd0, busy}, 64'd1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         spur_fb = 1'b0;
         check_val($sformatf("resn_k%0d", k), {63'd0, resn}, {63'd0, !(k >= 4 && k <= 6)});
         check_val($sformatf("start_k%0d", k), {63'd0, start}, {63'd0, (k == 10)});
      end

      t = 0;
      while (vccen !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_val("vccen_timeout", {63'd0, vccen}, 64'd1);
      check_val("vccen_after_p2", start_cnt, 3);
      spur_fb = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         spur_fb = 1'b0;
         check_val($sformatf("vcc_start_k%0d", k), {63'd0, start}, {63'd0, (k == 5)});
      end

      t = 0;
      while (done !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_val("done", {63'd0, done}, 64'd1);
      check_val("done_busy", {63'd0, busy}, 64'd0);
      check_val("done_pwr", {61'd0, pmoden, vccen, resn}, 64'd7);
      check_val("start_total", start_cnt, 4);
      check_val("queue_empty", exp_q.size(), 0);

      // i_EN held high after DONE must not restart anything.
      en = 1'b1;
      repeat (20) @(negedge clk);
      en = 1'b0;
      check_val("done_en_starts", start_cnt, 4);
      check_val("done_en_done", {63'd0, done}, 64'd1);

      // Asynchronous abort while waiting on P1, then a clean re-run.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk_pkt(0));
      exp_q.push_back(mk_pkt(1));
      base = start_cnt;
      pulse_en();
      t = 0;
      while (start_cnt < base + 2 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check_val("p1_reached", start_cnt, base + 2);
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_val("abort_idle", {62'd0, busy, pmoden}, 64'd0);
      push_all();
      base = start_cnt;
      pulse_en();
      t = 0;
      while (done !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check_val("rerun_done", {63'd0, done}, 64'd1);
      check_val("rerun_starts", start_cnt, base + 4);
      check_val("rerun_queue", exp_q.size(), 0);

      // No final byte ever returned: stuck in WAIT_TX with one strobe.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      auto_resp = 1'b0;
      exp_q.push_back(mk_pkt(0));
      base = start_cnt;
      pulse_en();
      repeat (100) @(negedge clk);
      check_val("stall_starts", start_cnt, base + 1);
      check_val("stall_busy", {63'd0, busy}, 64'd1);
      check_val("stall_done", {63'd0, done}, 64'd0);
      check_val("stall_data", data, 64'h0000_0000_0000_00AE);
      check_val("stall_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
